// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch driven by a 1 Hz tick, with start/stop, clear and optional lap freeze.
// Define STOPWATCH_LAP_EN to build the LAP state and the frozen display register.
module stopwatch_ctrl #(
  parameter int unsigned WRAP      = 1,
  parameter int unsigned MIN_LIMIT = 59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       BTN_START,
  input  logic       BTN_CLEAR,
  input  logic       BTN_LAP,
  output logic [3:0] SEC_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] MIN_TENS,
  output logic       RUNNING,
  output logic       OVF
);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Run   = 2'd1,
    Pause = 2'd2,
    Lap   = 2'd3
  } state_t;

  localparam logic [3:0] LimTens = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LimOnes = 4'(MIN_LIMIT % 10);

  state_t     state_q, state_d;
  logic [3:0] secOnes_q, secOnes_d;
  logic [3:0] secTens_q, secTens_d;
  logic [3:0] minOnes_q, minOnes_d;
  logic [3:0] minTens_q, minTens_d;
  logic       ovf_q, ovf_d;
  logic       running_q;

  logic       countEn;
  logic       atLimit;
  logic [4:0] secOnesStep;
  logic [4:0] secTensStep;
  logic [4:0] minOnesStep;

  // One BCD digit step: an out-of-range digit snaps to 0 without carrying.
  function automatic logic [4:0] bcdStep(input logic [3:0] q, input logic [3:0] maxVal,
                                         input logic carryIn);
    logic [4:0] r;
    r = {1'b0, q};
    if (q > maxVal) begin
      r = 5'd0;
    end else if (carryIn) begin
      if (q == maxVal) r = {1'b1, 4'd0};
      else             r = {1'b0, q + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    if (BTN_CLEAR) begin
      state_d = Idle;
    end else if (BTN_START) begin
      case (state_q)
        Idle:    state_d = Run;
        Run:     state_d = Pause;
        Pause:   state_d = Run;
        Lap:     state_d = Pause;
        default: state_d = Idle;
      endcase
`ifdef STOPWATCH_LAP_EN
    end else if (BTN_LAP) begin
      if (state_q == Run)      state_d = Lap;
      else if (state_q == Lap) state_d = Run;
`endif
    end
  end

  // Counting is gated on the pre-edge state, so a START leaving RUN still counts its tick.
  assign countEn = TICK && !BTN_CLEAR && ((state_q == Run) || (state_q == Lap));
  assign atLimit = (minTens_q == LimTens) && (minOnes_q == LimOnes) &&
                   (secTens_q == 4'd5) && (secOnes_q == 4'd9);

  assign secOnesStep = bcdStep(secOnes_q, 4'd9, 1'b1);
  assign secTensStep = bcdStep(secTens_q, 4'd5, secOnesStep[4]);
  assign minOnesStep = bcdStep(minOnes_q, 4'd9, secTensStep[4]);

  always_comb begin
    secOnes_d = secOnes_q;
    secTens_d = secTens_q;
    minOnes_d = minOnes_q;
    minTens_d = minTens_q;
    ovf_d     = ovf_q;
    if (BTN_CLEAR) begin
      secOnes_d = 4'd0;
      secTens_d = 4'd0;
      minOnes_d = 4'd0;
      minTens_d = 4'd0;
      ovf_d     = 1'b0;
    end else if (countEn) begin
      if (atLimit) begin
        ovf_d = 1'b1;
        if (WRAP != 0) begin
          secOnes_d = 4'd0;
          secTens_d = 4'd0;
          minOnes_d = 4'd0;
          minTens_d = 4'd0;
        end
      end else begin
        secOnes_d = secOnesStep[3:0];
        secTens_d = secTensStep[3:0];
        minOnes_d = minOnesStep[3:0];
        // Minute tens above 5 only arise from an upset; any counted tick clears them.
        if (minTens_q > 4'd5)     minTens_d = 4'd0;
        else if (minOnesStep[4])  minTens_d = (minTens_q == 4'd5) ? 4'd0 : minTens_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= Idle;
      secOnes_q <= 4'd0;
      secTens_q <= 4'd0;
      minOnes_q <= 4'd0;
      minTens_q <= 4'd0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secOnes_q <= secOnes_d;
      secTens_q <= secTens_d;
      minOnes_q <= minOnes_d;
      minTens_q <= minTens_d;
      ovf_q     <= ovf_d;
      running_q <= (state_d == Run) || (state_d == Lap);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [3:0] dispSecOnes_q;
  logic [3:0] dispSecTens_q;
  logic [3:0] dispMinOnes_q;
  logic [3:0] dispMinTens_q;

  // The display freezes only while the machine stays in LAP; otherwise it tracks the live count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dispSecOnes_q <= 4'd0;
      dispSecTens_q <= 4'd0;
      dispMinOnes_q <= 4'd0;
      dispMinTens_q <= 4'd0;
    end else if (!((state_q == Lap) && (state_d == Lap))) begin
      dispSecOnes_q <= secOnes_d;
      dispSecTens_q <= secTens_d;
      dispMinOnes_q <= minOnes_d;
      dispMinTens_q <= minTens_d;
    end
  end

  assign SEC_ONES = dispSecOnes_q;
  assign SEC_TENS = dispSecTens_q;
  assign MIN_ONES = dispMinOnes_q;
  assign MIN_TENS = dispMinTens_q;
`else
  logic unusedLap;
  assign unusedLap = BTN_LAP;

  assign SEC_ONES = secOnes_q;
  assign SEC_TENS = secTens_q;
  assign MIN_ONES = minOnes_q;
  assign MIN_TENS = minTens_q;
`endif

  assign RUNNING = running_q;
  assign OVF     = ovf_q;

endmodule
